// File: rtl/sq_root_pipe_if.sv
// Valid/ready bus between a radicand producer, the square-root unit and a result consumer.
interface sq_root_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH/2-1:0] out_root;
  logic [WIDTH/2:0]   out_rem;

  // Producer/consumer side of the bus.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_root,
    input  out_rem
  );

  // Square-root unit side of the bus.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_root,
    output out_rem
  );
endinterface

// File: rtl/sq_root_pipe.sv
// Sequential restoring integer square root: STEPS root bits resolved per clock,
// single operation in flight, valid/ready on both sides.
module sq_root_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sq_root_pipe_if.slave bus,
  output logic          busy_o
);

  localparam int unsigned H    = WIDTH / 2;
  localparam int unsigned N    = H / STEPS;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] d_q;
  logic [H-1:0]     root_q;
  logic [H:0]       rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [H-1:0]     out_root_q;
  logic [H:0]       out_rem_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] d_d;
  logic [H-1:0]     root_d;
  logic [H:0]       rem_d;
  logic [H+1:0]     trial;

  // STEPS chained restoring iterations on the working registers.
  always_comb begin
    d_d    = d_q;
    root_d = root_q;
    rem_d  = rem_q;
    trial  = '0;
    for (int s = 0; s < STEPS; s++) begin
      trial = {rem_d[H-1:0], d_d[WIDTH-1 -: 2]} - {root_d, 2'b01};
      if (trial[H+1]) begin
        // Negative trial: restore, keep the shifted-in pair.
        rem_d = {rem_d[H-2:0], d_d[WIDTH-1 -: 2]};
      end else begin
        rem_d = trial[H:0];
      end
      root_d = {root_d[H-2:0], ~trial[H+1]};
      d_d    = {d_d[WIDTH-3:0], 2'b00};
    end
  end

  // Control FSM with registered handshake outputs and result capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      d_q         <= '0;
      root_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            d_q        <= bus.in_data;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          d_q    <= d_d;
          root_q <= root_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            out_root_q  <= root_d;
            out_rem_q   <= rem_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_root  = out_root_q;
  assign bus.out_rem   = out_rem_q;
  assign busy_o        = busy_q;

endmodule
